// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared action bit indices, FSM states and default width for the Booth multiplier
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam int SINGLE = 0;
  localparam int DOUBLE = 1;
  localparam int NEG    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_encoder.sv
// rtl/booth_encoder.sv - radix-4 Booth recoding of one multiplier triplet into {neg, double, single}
module booth_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output logic [2:0] action_o
);

  always_comb begin
    action_o = 3'b000;
    case (triplet_i)
      3'b001, 3'b010: action_o[SINGLE] = 1'b1;
      3'b011:         action_o[DOUBLE] = 1'b1;
      3'b100:         begin action_o[NEG] = 1'b1; action_o[DOUBLE] = 1'b1; end
      3'b101, 3'b110: begin action_o[NEG] = 1'b1; action_o[SINGLE] = 1'b1; end
      default:        action_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth signed multiplier, one digit per cycle
// Define BOOTH_SEQ_ZERO_SKIP_EN to finish early once all remaining digits are zero.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [2:0]           action
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   y_q;      // multiplier with y[-1] appended, shifted right two bits per digit
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;

  logic [2:0]         enc;
  logic [WIDTH+1:0]   mag;
  logic [WIDTH+1:0]   pp;
  logic [PW-1:0]      pp_sh;
  logic [PW-1:0]      acc_d;
  logic               accept;
  logic               done_now;

  booth_encoder u_enc (
    .triplet_i (y_q[2:0]),
    .action_o  (enc)
  );

  always_comb begin
    mag = '0;
    if (enc[SINGLE])
      mag = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    else if (enc[DOUBLE])
      mag = {mcand_q[WIDTH-1], mcand_q, 1'b0};
    pp    = enc[NEG] ? (~mag + 1'b1) : mag;
    pp_sh = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt_q, 1'b0};
    acc_d = acc_q + pp_sh;
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
    // Remaining triplets are all 000/111 exactly when the unconsumed bits are all equal.
    done_now = (cnt_q == LAST) || (y_q[WIDTH:2] == {(WIDTH-1){y_q[WIDTH]}});
`else
    done_now = (cnt_q == LAST);
`endif
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign product   = acc_q;
  assign action    = (state_q == BUSY) ? enc : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state_q     <= BUSY;
      mcand_q     <= multiplicand;
      y_q         <= {multiplier, 1'b0};
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          y_q   <= {{2{y_q[WIDTH]}}, y_q[WIDTH:2]};
          if (done_now) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - self-checking bench for booth_seq_mult (vector table, corner sequences, random)
module tb_booth_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [2:0]  action;

  int n_cmp;
  int n_fail;
  logic [2:0] seen_act[8];
  int seen_lat;

  booth_seq_mult #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .action       (action)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Radix-4 Booth digit value in {-2..2}, from the arithmetic definition.
  function automatic int digit(input logic [7:0] y, input int i);
    logic [8:0] ext;
    int lo, mid, hi;
    ext = {y, 1'b0};
    lo  = int'(ext[2*i]);
    mid = int'(ext[2*i+1]);
    hi  = int'(ext[2*i+2]);
    return lo + mid - 2 * hi;
  endfunction

  function automatic logic [2:0] exp_act(input logic [7:0] y, input int i);
    case (digit(y, i))
      1:       return 3'b001;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int exp_lat(input logic [7:0] y);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
    int last;
    last = 0;
    for (int i = 0; i < 4; i++)
      if (digit(y, i) != 0) last = i + 1;
    return (last == 0) ? 1 : last;
`else
    return 4;
`endif
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    int n;
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("issue.in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [7:0] a, input logic [7:0] b, input int hold, input string tag);
    int lat;
    int pa;
    logic [15:0] held;
    pa  = $signed(a) * $signed(b);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) seen_act[lat] = action;
      step();
      lat++;
    end
    seen_lat = lat;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat(b)));
    check({tag, ".product"}, 32'(product), 32'(pa[15:0]));
    check({tag, ".action_done"}, 32'(action), 32'd0);
    for (int i = 0; i < lat && i < 4; i++)
      check($sformatf("%s.action%0d", tag, i), 32'(seen_act[i]), 32'(exp_act(b, i)));
    held = product;
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, ".held_product"}, 32'(product), 32'(held));
      check({tag, ".held_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".held_out_valid"}, 32'(out_valid), 32'd1);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] held;
    logic [7:0]  ra, rb;
    int          seen_ov;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    vecs[0] = '{8'd7,    8'd3,    16'h0015};
    vecs[1] = '{8'h80,   8'h80,   16'h4000};
    vecs[2] = '{8'd127,  8'hFF,   16'hFF81};
    vecs[3] = '{8'd0,    8'd0,    16'h0000};
    vecs[4] = '{8'hFF,   8'hFF,   16'h0001};
    vecs[5] = '{8'h80,   8'd127,  16'hC080};
    vecs[6] = '{8'd127,  8'd127,  16'h3F01};
    vecs[7] = '{8'h80,   8'd1,    16'hFF80};
    vecs[8] = '{8'd5,    8'h6B,   16'h0217};

    #2;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.product", 32'(product), 32'd0);
    check("reset.action", 32'(action), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      issue(vecs[v].a, vecs[v].b);
      collect(vecs[v].a, vecs[v].b, 0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d.table_product", v), 32'(product), 32'(vecs[v].p));
      if (v == 8) begin
        check("act6b.d0", 32'(seen_act[0]), 32'b101);
        check("act6b.d1", 32'(seen_act[1]), 32'b101);
        check("act6b.d2", 32'(seen_act[2]), 32'b101);
        check("act6b.d3", 32'(seen_act[3]), 32'b010);
      end
      drain($sformatf("vec%0d", v));
    end

    // Backpressure for 10 cycles, then simultaneous output and input handshake.
    issue(8'd100, 8'hFD);
    collect(8'd100, 8'hFD, 10, "bp");
    held = product;
    multiplicand = 8'hC3;
    multiplier   = 8'h5A;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    #1;
    check("b2b.in_ready_done", 32'(in_ready), 32'd1);
    check("b2b.product_before", 32'(product), 32'(held));
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b.busy_out_valid", 32'(out_valid), 32'd0);
    check("b2b.busy_in_ready", 32'(in_ready), 32'd0);
    collect(8'hC3, 8'h5A, 2, "b2b");
    drain("b2b");

    // Single-digit multiplier: one BUSY cycle with zero skipping, full latency otherwise.
    issue(8'h9C, 8'd1);
    collect(8'h9C, 8'd1, 0, "one");
    drain("one");

    // Reset asserted mid-operation in the second BUSY cycle.
    issue(8'd7, 8'd3);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.product", 32'(product), 32'd0);
    check("abort.action", 32'(action), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_ov = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) seen_ov++;
    end
    out_ready = 1'b0;
    check("abort.no_out_valid", 32'(seen_ov), 32'd0);

    for (int r = 0; r < 150; r++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (r % 10 == 0) rb = 8'($urandom_range(0, 3));
      issue(ra, rb);
      collect(ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d", r));
      drain($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
